// File: rtl/imm_encode.sv
// imm_encode: packs an immediate into a RISC-V instruction template behind a 1-cycle, skid-buffered valid/ready pipe
module imm_encode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  imm_type,
    input  logic [31:0] imm,
    input  logic [31:0] base,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] inst,
    output logic        err,
    input  logic        clr_cnt,
    output logic [15:0] err_cnt
);
    localparam logic [2:0] RTYPE   = 3'd0;
    localparam logic [2:0] ITYPE   = 3'd1;
    localparam logic [2:0] STYPE   = 3'd2;
    localparam logic [2:0] BTYPE   = 3'd3;
    localparam logic [2:0] UTYPE   = 3'd4;
    localparam logic [2:0] JTYPE   = 3'd5;
    localparam logic [2:0] CSRTYPE = 3'd6;

    logic [31:0] mask, field, enc_inst;
    logic        enc_err;
    logic        sx11, sx12, sx20;
    logic        out_valid_q, err_q, skid_full_q, skid_err_q;
    logic [31:0] inst_q, skid_inst_q;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        accept, drain, out_free;

    // Upper bits must be a pure sign extension of the field's top bit
    assign sx11 = &imm[31:11] | ~|imm[31:11];
    assign sx12 = &imm[31:12] | ~|imm[31:12];
    assign sx20 = &imm[31:20] | ~|imm[31:20];

    assign accept   = in_valid && in_ready;
    assign drain    = out_valid_q && out_ready;
    assign out_free = !out_valid_q || out_ready;

    // Select the immediate field positions and value for the type; errors blank the field
    always_comb begin
        mask    = 32'h0;
        field   = 32'h0;
        enc_err = 1'b0;
        case (imm_type)
            RTYPE: ;
            ITYPE: begin
                mask    = 32'hFFF0_0000;
                field   = {imm[11:0], 20'h0};
                enc_err = !sx11;
            end
            STYPE: begin
                mask    = 32'hFE00_0F80;
                field   = {imm[11:5], 13'h0, imm[4:0], 7'h0};
                enc_err = !sx11;
            end
            BTYPE: begin
                mask    = 32'hFE00_0F80;
                field   = {imm[12], imm[10:5], 13'h0, imm[4:1], imm[11], 7'h0};
                enc_err = !sx12 || imm[0];
            end
            UTYPE: begin
                mask    = 32'hFFFF_F000;
                field   = {imm[31:12], 12'h0};
                enc_err = |imm[11:0];
            end
            JTYPE: begin
                mask    = 32'hFFFF_F000;
                field   = {imm[20], imm[10:1], imm[11], imm[19:12], 12'h0};
                enc_err = !sx20 || imm[0];
            end
            CSRTYPE: begin
                mask    = 32'h000F_8000;
                field   = {12'h0, imm[4:0], 15'h0};
                enc_err = |imm[31:5];
            end
            default: enc_err = 1'b1;
        endcase
        enc_inst = (base & ~mask) | (enc_err ? 32'h0 : field);
    end

    // Saturating error counter; clear wins over a coincident increment
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (drain && err_q && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        if (clr_cnt) err_cnt_d = 16'h0;
    end

    // Output stage refills from the skid first to keep order, otherwise straight from the input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            inst_q      <= 32'h0;
            err_q       <= 1'b0;
            skid_full_q <= 1'b0;
            skid_inst_q <= 32'h0;
            skid_err_q  <= 1'b0;
            err_cnt_q   <= 16'h0;
        end else begin
            if (out_free) begin
                out_valid_q <= skid_full_q || accept;
                if (skid_full_q) begin
                    inst_q <= skid_inst_q;
                    err_q  <= skid_err_q;
                end else if (accept) begin
                    inst_q <= enc_inst;
                    err_q  <= enc_err;
                end
            end else if (accept) begin
                skid_inst_q <= enc_inst;
                skid_err_q  <= enc_err;
            end
            skid_full_q <= !out_free && (skid_full_q || accept);
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign in_ready  = !skid_full_q;
    assign out_valid = out_valid_q;
    assign inst      = inst_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_imm_encode.sv
// tb_imm_encode: scoreboard bench for imm_encode
module tb_imm_encode;
    localparam logic [2:0] RTYPE = 3'd0, ITYPE = 3'd1, STYPE = 3'd2, BTYPE = 3'd3;
    localparam logic [2:0] UTYPE = 3'd4, JTYPE = 3'd5, CSRTYPE = 3'd6;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0, clr_cnt = 1'b0;
    logic [2:0]  imm_type = 3'd0;
    logic [31:0] imm = 32'h0, base = 32'h0;
    logic        in_ready, out_valid, err;
    logic [31:0] inst;
    logic [15:0] err_cnt;

    int          n_cmp = 0, n_bad = 0;
    logic [32:0] sb[$];
    logic [15:0] cnt_m = 16'h0;
    logic        last_acc = 1'b0;

    imm_encode dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .imm_type(imm_type), .imm(imm), .base(base), .out_valid(out_valid),
        .out_ready(out_ready), .inst(inst), .err(err), .clr_cnt(clr_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference encoder written from range rules and field placement
    function automatic logic [32:0] model(input logic [2:0] t, input logic [31:0] v, input logic [31:0] b);
        logic [31:0] r;
        logic        bad;
        int          s;
        r = b;
        s = $signed(v);
        bad = 1'b0;
        case (t)
            RTYPE: ;
            ITYPE: begin
                bad = s < -2048 || s > 2047;
                r[31:20] = bad ? 12'h0 : v[11:0];
            end
            STYPE: begin
                bad = s < -2048 || s > 2047;
                r[31:25] = bad ? 7'h0 : v[11:5];
                r[11:7]  = bad ? 5'h0 : v[4:0];
            end
            BTYPE: begin
                bad = s < -4096 || s > 4095 || v[0];
                r[31]    = bad ? 1'b0 : v[12];
                r[30:25] = bad ? 6'h0 : v[10:5];
                r[11:8]  = bad ? 4'h0 : v[4:1];
                r[7]     = bad ? 1'b0 : v[11];
            end
            UTYPE: begin
                bad = v[11:0] != 12'h0;
                r[31:12] = bad ? 20'h0 : v[31:12];
            end
            JTYPE: begin
                bad = s < -(1 << 20) || s > (1 << 20) - 1 || v[0];
                r[31]    = bad ? 1'b0 : v[20];
                r[30:21] = bad ? 10'h0 : v[10:1];
                r[20]    = bad ? 1'b0 : v[11];
                r[19:12] = bad ? 8'h0 : v[19:12];
            end
            CSRTYPE: begin
                bad = v > 32'd31;
                r[19:15] = bad ? 5'h0 : v[4:0];
            end
            default: bad = 1'b1;
        endcase
        return {bad, r};
    endfunction

    // One clock: book the handshakes the coming edge will perform, then check the counter
    task automatic step();
        logic [32:0] e;
        logic [15:0] nc;
        nc = cnt_m;
        last_acc = in_valid && in_ready;
        if (last_acc) sb.push_back(model(imm_type, imm, base));
        if (out_valid && out_ready) begin
            check("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("inst", inst, e[31:0]);
                check("err", err, e[32]);
                if (e[32] && nc != 16'hFFFF) nc = nc + 16'd1;
            end
        end
        if (clr_cnt) nc = 16'h0;
        @(posedge clk);
        @(negedge clk);
        cnt_m = nc;
        check("err_cnt", err_cnt, cnt_m);
    endtask

    task automatic send_chk(input string tag, input logic [2:0] t, input logic [31:0] v,
                            input logic [31:0] b, input logic [31:0] ei, input logic ee);
        in_valid = 1'b1; imm_type = t; imm = v; base = b; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_inst"}, inst, ei);
        check({tag, "_err"}, err, ee);
    endtask

    initial begin
        int cyc;
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_inst", inst, 0);
        check("rst_err_cnt", err_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        send_chk("i_type", ITYPE, 32'hFFFFF800, 32'h00000013, 32'h80000013, 1'b0);
        send_chk("b_type", BTYPE, 32'h00000FFE, 32'h00000063, 32'h7E000FE3, 1'b0);
        send_chk("j_odd", JTYPE, 32'h00000001, 32'h0000006F, 32'h0000006F, 1'b1);
        send_chk("u_type", UTYPE, 32'h12345000, 32'h00000037, 32'h12345037, 1'b0);
        check("cnt_after_j", err_cnt, 1);
        send_chk("u_low", UTYPE, 32'h12345001, 32'h00000037, 32'h00000037, 1'b1);
        send_chk("csr", CSRTYPE, 32'h0000001F, 32'h00005073, 32'h000FD073, 1'b0);
        send_chk("bad_type", 3'd7, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
        step();

        // Stall the sink: A lands in output, B in skid, C waits at the source
        out_ready = 1'b0;
        in_valid = 1'b1; imm_type = ITYPE; base = 32'h00000093;
        imm = 32'd1; step();
        imm = 32'd2; step();
        imm = 32'd3; step();
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        step();
        out_ready = 1'b1;
        step();
        check("drain_b_valid", out_valid, 1);
        check("drain_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("drain_c_valid", out_valid, 1);
        step();
        check("drain_done", sb.size(), 0);

        // Random traffic with backpressure; the source holds an item until taken
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || last_acc) begin
                in_valid = $urandom_range(0, 3) != 0;
                imm_type = 3'($urandom_range(0, 7));
                base = $urandom;
                case ($urandom_range(0, 3))
                    0: imm = $urandom;
                    1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                    2: imm = $urandom & 32'hFFFFF000;
                    default: imm = 32'($urandom_range(0, 40));
                endcase
            end
            out_ready = $urandom_range(0, 2) != 0;
            clr_cnt = $urandom_range(0, 40) == 0;
            step();
        end
        clr_cnt = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        check("rand_drained", sb.size(), 0);

        // Saturate the counter with a continuous stream of errored items
        clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
        in_valid = 1'b1; imm_type = ITYPE; imm = 32'h00010000; base = 32'h13;
        cyc = 0;
        while (cnt_m != 16'hFFFF && cyc < 70000) begin
            step();
            cyc++;
        end
        check("sat_reached", cnt_m == 16'hFFFF, 1);
        step();
        step();
        check("sat_hold", err_cnt, 16'hFFFF);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        check("clr_priority", err_cnt, 0);
        step();

        // Asynchronous reset with output valid and skid full
        out_ready = 1'b0;
        step(); step(); step();
        check("pre_rst_skid", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_err_cnt", err_cnt, 0);
        check("arst_inst", inst, 0);
        check("arst_err", err, 0);
        sb.delete();
        cnt_m = 16'h0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_chk("post_rst", ITYPE, 32'h00000005, 32'h00000013, 32'h00500013, 1'b0);
        step();
        check("post_rst_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
